// File: rtl/pipelined_sel_mux_if.sv
// Bus interface for pipelined_sel_mux: upstream payload/handshake plus the
// registered downstream result and its handshake.
// Optional out_parity wire is present when PIPELINED_SEL_MUX_PARITY_EN is defined.
interface pipelined_sel_mux_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 8
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    scan_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
`ifdef PIPELINED_SEL_MUX_PARITY_EN
  logic                    out_parity;
`endif

  modport master (
    output in_data, sel, scan_mode, in_valid, out_ready,
`ifdef PIPELINED_SEL_MUX_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  in_data, sel, scan_mode, in_valid, out_ready,
`ifdef PIPELINED_SEL_MUX_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/pipelined_sel_mux.sv
// pipelined_sel_mux: N:1 WIDTH-bit selector with one registered output stage
// and a valid/ready handshake. DIRECT mode selects by the sel input; SCAN mode
// uses an internal round-robin pointer that steps on every accepted transfer.
// Optional feature macro: PIPELINED_SEL_MUX_PARITY_EN adds out_parity.
module pipelined_sel_mux #(
  parameter int  WIDTH  = 64,
  parameter int  NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input logic               clk,
  input logic               reset,
  pipelined_sel_mux_if.slave bus
);

  localparam logic [SEL_W:0]   IDX_LIMIT = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] PTR_LAST  = SEL_W'(NUM_IN - 1);

  logic             accept;
  logic             fire;
  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] idx;
  logic             idx_err;
  logic [WIDTH-1:0] mux_data;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             err_p1;
  logic             vld_p1;
`ifdef PIPELINED_SEL_MUX_PARITY_EN
  logic             parity_p1;
`endif

  // Round-robin successor; wraps explicitly so non-power-of-two NUM_IN works.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + SEL_W'(1);
  endfunction

  // Even/odd parity of a loaded word.
  function automatic logic word_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Single output register: a new word may enter whenever the slot is empty
  // or is being drained this very cycle.
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = vld_p1 && bus.out_ready;

  assign idx     = bus.scan_mode ? scan_ptr : bus.sel;
  assign idx_err = ({1'b0, idx} >= IDX_LIMIT);

  // Channel mux; an index with no matching channel yields zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (idx == SEL_W'(k)) mux_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // ---- stage p0 -> p1 boundary ----

  // Control: output valid flag and the scan pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      scan_ptr <= '0;
    end else begin
      if (accept)    vld_p1 <= 1'b1;
      else if (fire) vld_p1 <= 1'b0;
      if (accept && bus.scan_mode) scan_ptr <= next_ptr(scan_ptr);
    end
  end

  // Payload: captured only on accept, otherwise held across back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p1   <= '0;
      sel_p1    <= '0;
      err_p1    <= 1'b0;
`ifdef PIPELINED_SEL_MUX_PARITY_EN
      parity_p1 <= 1'b0;
`endif
    end else if (accept) begin
      data_p1   <= idx_err ? '0 : mux_data;
      sel_p1    <= idx;
      err_p1    <= idx_err;
`ifdef PIPELINED_SEL_MUX_PARITY_EN
      parity_p1 <= idx_err ? 1'b0 : word_parity(mux_data);
`endif
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_sel   = sel_p1;
  assign bus.out_err   = err_p1;
  assign bus.out_valid = vld_p1;
`ifdef PIPELINED_SEL_MUX_PARITY_EN
  assign bus.out_parity = parity_p1;
`endif

endmodule

// File: tb/tb_pipelined_sel_mux.sv
// Scoreboard bench for pipelined_sel_mux: an 8-channel and a 5-channel
// instance, directed stimulus pushing expected results, monitors popping them.
module tb_pipelined_sel_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_sel_mux_if #(.WIDTH(64), .NUM_IN(8)) if8 ();
  pipelined_sel_mux_if #(.WIDTH(64), .NUM_IN(5)) if5 ();

  pipelined_sel_mux #(.WIDTH(64), .NUM_IN(8)) u_dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  pipelined_sel_mux #(.WIDTH(64), .NUM_IN(5)) u_dut5 (.clk(clk), .reset(reset), .bus(if5.slave));

  typedef struct {
    logic [63:0] data;
    logic [2:0]  sel;
    logic        err;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stalls   = 0;
  int   scan_exp [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};

  function automatic logic [63:0] ch(input int k);
    return 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [63:0] d,
                       input logic [2:0] s, input logic er, input logic par);
    check({tag, "_data"}, d, e.data);
    check({tag, "_sel"}, 64'(s), 64'(e.sel));
    check({tag, "_err"}, 64'(er), 64'(e.err));
`ifdef PIPELINED_SEL_MUX_PARITY_EN
    check({tag, "_parity"}, 64'(par), 64'(^e.data));
`endif
  endtask

  // Monitor for the 8-channel instance: a transfer completes on each cycle
  // sampled with out_valid && out_ready.
  always @(negedge clk) begin
    if (reset === 1'b1 && if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut8_unexpected_output: got sel %0d, no transfer outstanding", if8.out_sel);
      end else begin
`ifdef PIPELINED_SEL_MUX_PARITY_EN
        score("dut8", q8.pop_front(), if8.out_data, if8.out_sel, if8.out_err, if8.out_parity);
`else
        score("dut8", q8.pop_front(), if8.out_data, if8.out_sel, if8.out_err, 1'b0);
`endif
      end
    end
  end

  // Monitor for the 5-channel instance.
  always @(negedge clk) begin
    if (reset === 1'b1 && if5.out_valid && if5.out_ready) begin
      if (q5.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut5_unexpected_output: got sel %0d, no transfer outstanding", if5.out_sel);
      end else begin
`ifdef PIPELINED_SEL_MUX_PARITY_EN
        score("dut5", q5.pop_front(), if5.out_data, if5.out_sel, if5.out_err, if5.out_parity);
`else
        score("dut5", q5.pop_front(), if5.out_data, if5.out_sel, if5.out_err, 1'b0);
`endif
      end
    end
  end

  // Offer one transfer, wait (bounded) for acceptance, push its expectation.
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic xfer(input bit use8, input logic [2:0] s, input logic mode,
                      input logic [2:0] exp_sel, input logic [63:0] exp_data, input logic exp_err);
    int   waited = 0;
    bit   ok = 1'b1;
    exp_t e;
    if (use8) begin if8.sel = s; if8.scan_mode = mode; if8.in_valid = 1'b1; end
    else      begin if5.sel = s; if5.scan_mode = mode; if5.in_valid = 1'b1; end
    @(negedge clk);
    while (!(use8 ? if8.in_ready : if5.in_ready)) begin
      waited++;
      if (waited > 50) begin
        n_checks++; n_fail++; ok = 1'b0;
        $display("FAIL accept_timeout: got no in_ready after %0d cycles, required acceptance", waited);
        break;
      end
      @(negedge clk);
    end
    stalls += waited;
    if (ok) begin
      e.data = exp_data; e.sel = exp_sel; e.err = exp_err;
      if (use8) q8.push_back(e); else q5.push_back(e);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if5.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q5.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    if (q8.size() != 0 || q5.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d outstanding, required 0", q8.size(), q5.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    if8.in_data = '0; if8.sel = '0; if8.scan_mode = 1'b0; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    if5.in_data = '0; if5.sel = '0; if5.scan_mode = 1'b0; if5.in_valid = 1'b1; if5.out_ready = 1'b1;

    // Reset held for 3 cycles with in_valid asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst8_out_valid", 64'(if8.out_valid), 64'd0);
    check("rst8_out_data", if8.out_data, 64'd0);
    check("rst8_out_sel", 64'(if8.out_sel), 64'd0);
    check("rst8_out_err", 64'(if8.out_err), 64'd0);
    check("rst8_in_ready", 64'(if8.in_ready), 64'd1);
    check("rst5_out_valid", 64'(if5.out_valid), 64'd0);
    check("rst5_out_data", if5.out_data, 64'd0);
    check("rst5_in_ready", 64'(if5.in_ready), 64'd1);
`ifdef PIPELINED_SEL_MUX_PARITY_EN
    check("rst8_out_parity", 64'(if8.out_parity), 64'd0);
`endif
    if8.in_valid = 1'b0; if5.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) if8.in_data[k*64 +: 64] = ch(k);
    for (int k = 0; k < 5; k++) if5.in_data[k*64 +: 64] = ch(k);
    @(posedge clk); #1;

    // DIRECT sweep on 8 channels, one transfer per cycle.
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      xfer(1'b1, 3'(k), 1'b0, 3'(k), ch(k), 1'b0);
      if (k == 0) check("first_accept_valid", 64'(if8.out_valid), 64'd1);
    end
    check("sweep_stall_cycles", 64'(stalls), 64'd0);
    drain();

    // Back-pressure: channel 3 held while channel 5 waits.
    xfer(1'b1, 3'd3, 1'b0, 3'd3, ch(3), 1'b0);
    if8.out_ready = 1'b0;
    if8.sel = 3'd5; if8.scan_mode = 1'b0; if8.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(if8.in_ready), 64'd0);
      check("bp_out_valid", 64'(if8.out_valid), 64'd1);
      check("bp_hold_data", if8.out_data, ch(3));
      check("bp_hold_sel", 64'(if8.out_sel), 64'd3);
    end
    @(posedge clk); #1;
    if8.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(if8.in_ready), 64'd1);
    begin
      exp_t e;
      e.data = ch(5); e.sel = 3'd5; e.err = 1'b0;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_bubble_valid", 64'(if8.out_valid), 64'd1);
    check("bp_no_bubble_sel", 64'(if8.out_sel), 64'd5);
    drain();

    // SCAN wrap on 5 channels; sel input is ignored in SCAN mode.
    for (int i = 0; i < 12; i++)
      xfer(1'b0, 3'd7, 1'b1, 3'(scan_exp[i]), ch(scan_exp[i]), 1'b0);
    xfer(1'b0, 3'd4, 1'b0, 3'd4, ch(4), 1'b0);
    xfer(1'b0, 3'd0, 1'b0, 3'd0, ch(0), 1'b0);
    xfer(1'b0, 3'd7, 1'b1, 3'd2, ch(2), 1'b0);

    // Out-of-range select in DIRECT mode.
    xfer(1'b0, 3'd6, 1'b0, 3'd6, 64'd0, 1'b1);
    check("oor_out_err", 64'(if5.out_err), 64'd1);
    check("oor_out_valid", 64'(if5.out_valid), 64'd1);
    xfer(1'b0, 3'd2, 1'b0, 3'd2, ch(2), 1'b0);
    check("oor_clear_err", 64'(if5.out_err), 64'd0);

`ifdef PIPELINED_SEL_MUX_PARITY_EN
    // Parity of explicit words.
    if5.in_data[0*64 +: 64] = 64'h0000_0000_0000_0007;
    if5.in_data[1*64 +: 64] = 64'h0000_0000_0000_0003;
    xfer(1'b0, 3'd0, 1'b0, 3'd0, 64'h7, 1'b0);
    check("parity_7", 64'(if5.out_parity), 64'd1);
    xfer(1'b0, 3'd1, 1'b0, 3'd1, 64'h3, 1'b0);
    check("parity_3", 64'(if5.out_parity), 64'd0);
    xfer(1'b0, 3'd6, 1'b0, 3'd6, 64'd0, 1'b1);
    check("parity_err", 64'(if5.out_parity), 64'd0);
`endif

    drain();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
